// File: rtl/snake_pkg.sv
// Shared definitions for the snake playfield: map geometry, tile codes,
// the tile-to-colour palette and the tile arbiter FSM states.
package snake_pkg;

    localparam int TILE_SHIFT = 4;               // 16x16 pixel tiles
    localparam int COLS       = 50;              // 800 >> TILE_SHIFT
    localparam int ROWS       = 38;              // last row is only half visible
    localparam int CODE_W     = 3;
    localparam int ADDR_W     = 11;
    localparam int MAP_SIZE   = COLS * ROWS;     // 1900 tiles

    localparam logic [CODE_W-1:0] TILE_BG   = CODE_W'(0);
    localparam logic [CODE_W-1:0] TILE_BODY = CODE_W'(1);
    localparam logic [CODE_W-1:0] TILE_HEAD = CODE_W'(2);
    localparam logic [CODE_W-1:0] TILE_FOOD = CODE_W'(3);
    localparam logic [CODE_W-1:0] TILE_WALL = CODE_W'(4);

    typedef enum logic [1:0] {
        IDLE,
        WR_PEND,
        CLEAR
    } arb_state_t;

    // 2:2:2 colour for each tile code; unused codes show as white
    function automatic logic [5:0] palette(input logic [CODE_W-1:0] code);
        logic [5:0] rgb;
        case (code)
            TILE_BG:   rgb = 6'b000000;
            TILE_BODY: rgb = 6'b001100;
            TILE_HEAD: rgb = 6'b111100;
            TILE_FOOD: rgb = 6'b110000;
            TILE_WALL: rgb = 6'b010101;
            default:   rgb = 6'b111111;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// Combinational tile address row*COLS + col, built as a sum of shifted
// copies of row (one term per set bit of COLS) so no multiplier is inferred.
module tile_addr_calc
    import snake_pkg::*;
(
    input  logic [7:0]        row,
    input  logic [7:0]        col,
    output logic [ADDR_W-1:0] addr
);

    localparam int COL_BITS = $clog2(COLS + 1);

    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] partial [COL_BITS+1];

    assign row_ext    = ADDR_W'(row);
    assign partial[0] = ADDR_W'(col);

    genvar gi;
    generate
        for (gi = 0; gi < COL_BITS; gi++) begin : g_term
            if (((COLS >> gi) & 1) != 0) begin : g_add
                assign partial[gi+1] = partial[gi] + (row_ext << gi);
            end else begin : g_pass
                assign partial[gi+1] = partial[gi];
            end
        end
    endgenerate

    assign addr = partial[COL_BITS];

endmodule

// File: rtl/vga_tile_arbiter.sv
// Tile-map RAM arbiter: pixel fetch has absolute priority, game writes and
// the full-map clear use the cycles left over. Also converts tile codes to
// colour and derives a once-per-frame tick from vsync.
module vga_tile_arbiter
    import snake_pkg::*;
(
    input  logic              clk_fpga,
    input  logic              rst_n,
    input  logic [11:0]       x,
    input  logic [11:0]       y,
    input  logic              vga_v_out,
    output logic [5:0]        rgb_data,
    output logic              frame_tick,
    input  logic              wr_req,
    input  logic [5:0]        wr_col,
    input  logic [5:0]        wr_row,
    input  logic [CODE_W-1:0] wr_code,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [CODE_W-1:0] mem_wdata,
    input  logic [CODE_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAP_SIZE - 1);

    arb_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] last_addr_reg, last_addr_next;
    logic              dirty_reg, dirty_next;
    logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;
    logic              clr_busy_reg, clr_busy_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_we_reg, mem_we_next;
    logic [CODE_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              rd_issue_reg, rd_issue_next;
    logic              rd_valid_reg;
    logic [5:0]        rgb_reg;
    logic              ack_pipe_reg, ack_pipe_next;
    logic              wr_ack_reg, wr_ack_next;
    logic              wr_err_reg, wr_err_next;
    logic [1:0]        vs_sync_reg;
    logic              vs_prev_reg;
    logic              frame_tick_reg;

    logic [ADDR_W-1:0] pix_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              read_slot;
    logic              wr_in_range;
    logic              wr_fire;
    logic [ADDR_W-1:0] wr_fire_addr;

    tile_addr_calc u_pix_addr (
        .row  (8'(y >> TILE_SHIFT)),
        .col  (8'(x >> TILE_SHIFT)),
        .addr (pix_addr)
    );

    tile_addr_calc u_wr_addr (
        .row  (8'(wr_row)),
        .col  (8'(wr_col)),
        .addr (wr_addr)
    );

    // A fetch is needed whenever the beam enters a new tile or the shown tile was rewritten
    assign read_slot   = (pix_addr != last_addr_reg) || dirty_reg;
    assign wr_in_range = (wr_col < 6'(COLS)) && (wr_row < 6'(ROWS));

    // Slot arbitration, write/clear FSM and RAM port drive
    always_comb begin
        state_next     = state_reg;
        last_addr_next = last_addr_reg;
        dirty_next     = dirty_reg;
        clr_idx_next   = clr_idx_reg;
        clr_busy_next  = clr_busy_reg;
        mem_addr_next  = mem_addr_reg;
        mem_we_next    = 1'b0;
        mem_wdata_next = mem_wdata_reg;
        rd_issue_next  = 1'b0;
        ack_pipe_next  = 1'b0;
        wr_ack_next    = ack_pipe_reg;
        wr_err_next    = 1'b0;
        wr_fire        = 1'b0;
        wr_fire_addr   = '0;

        if (read_slot) begin
            mem_addr_next  = pix_addr;
            last_addr_next = pix_addr;
            dirty_next     = 1'b0;
            rd_issue_next  = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next    = CLEAR;
                    clr_idx_next  = '0;
                    clr_busy_next = 1'b1;
                end else if (wr_req && !ack_pipe_reg && !wr_ack_reg) begin
                    // the ack still in flight belongs to the request being held high
                    state_next = WR_PEND;
                end
            end
            WR_PEND: begin
                if (!wr_in_range) begin
                    wr_ack_next = 1'b1;
                    wr_err_next = 1'b1;
                    state_next  = IDLE;
                end else if (!read_slot) begin
                    wr_fire        = 1'b1;
                    wr_fire_addr   = wr_addr;
                    mem_wdata_next = wr_code;
                    ack_pipe_next  = 1'b1;
                    state_next     = IDLE;
                end
            end
            CLEAR: begin
                if (!read_slot) begin
                    wr_fire        = 1'b1;
                    wr_fire_addr   = clr_idx_reg;
                    mem_wdata_next = TILE_BG;
                    clr_idx_next   = clr_idx_reg + ADDR_W'(1);
                    if (clr_idx_reg == LAST_IDX) begin
                        clr_busy_next = 1'b0;
                        state_next    = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (wr_fire) begin
            mem_we_next   = 1'b1;
            mem_addr_next = wr_fire_addr;
            // overwriting the tile on screen forces a refetch next cycle
            if (wr_fire_addr == last_addr_reg) begin
                dirty_next = 1'b1;
            end
        end
    end

    // FSM, slot tracking and registered RAM/handshake outputs
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_addr_reg <= '1;
            dirty_reg     <= 1'b1;
            clr_idx_reg   <= '0;
            clr_busy_reg  <= 1'b0;
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= '0;
            rd_issue_reg  <= 1'b0;
            ack_pipe_reg  <= 1'b0;
            wr_ack_reg    <= 1'b0;
            wr_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_addr_reg <= last_addr_next;
            dirty_reg     <= dirty_next;
            clr_idx_reg   <= clr_idx_next;
            clr_busy_reg  <= clr_busy_next;
            mem_addr_reg  <= mem_addr_next;
            mem_we_reg    <= mem_we_next;
            mem_wdata_reg <= mem_wdata_next;
            rd_issue_reg  <= rd_issue_next;
            ack_pipe_reg  <= ack_pipe_next;
            wr_ack_reg    <= wr_ack_next;
            wr_err_reg    <= wr_err_next;
        end
    end

    // Colour pipeline: capture RAM data the cycle after a fetch, hold otherwise
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rgb_reg      <= '0;
        end else begin
            rd_valid_reg <= rd_issue_reg;
            if (rd_valid_reg) begin
                rgb_reg <= palette(mem_rdata);
            end
        end
    end

    // Synchronise vsync and pulse on its falling edge; idle level is high
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync_reg    <= 2'b11;
            vs_prev_reg    <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            vs_sync_reg    <= {vs_sync_reg[0], vga_v_out};
            vs_prev_reg    <= vs_sync_reg[1];
            frame_tick_reg <= vs_prev_reg & ~vs_sync_reg[1];
        end
    end

    assign rgb_data   = rgb_reg;
    assign frame_tick = frame_tick_reg;
    assign wr_ack     = wr_ack_reg;
    assign wr_err     = wr_err_reg;
    assign clr_busy   = clr_busy_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_we     = mem_we_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_vga_tile_arbiter.sv
// Bench for vga_tile_arbiter: external RAM, tile-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_vga_tile_arbiter;

    logic        clk_fpga;
    logic        rst_n;
    logic [11:0] x, y;
    logic        vga_v_out;
    logic [5:0]  rgb_data;
    logic        frame_tick;
    logic        wr_req;
    logic [5:0]  wr_col, wr_row;
    logic [2:0]  wr_code;
    logic        wr_ack, wr_err;
    logic        clr_req;
    logic        clr_busy;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;

    vga_tile_arbiter dut (
        .clk_fpga   (clk_fpga),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .vga_v_out  (vga_v_out),
        .rgb_data   (rgb_data),
        .frame_tick (frame_tick),
        .wr_req     (wr_req),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_code    (wr_code),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk_fpga = 1'b0;
        forever #5 clk_fpga = ~clk_fpga;
    end

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    function automatic logic [2:0] preset(input int a);
        case (a)
            0:       return 3'd1;
            50:      return 3'd2;
            51:      return 3'd3;
            52:      return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic int pal(input int code);
        case (code)
            0:       return 6'b000000;
            1:       return 6'b001100;
            2:       return 6'b111100;
            3:       return 6'b110000;
            4:       return 6'b010101;
            default: return 6'b111111;
        endcase
    endfunction

    // External single-port RAM, one-cycle read latency
    logic [2:0] ram [2048];
    always @(posedge clk_fpga) begin
        if (!rst_n) begin
            for (int i = 0; i < 2048; i++) ram[i] <= preset(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Stimulus-side expectations
    int exp_wr_addr = 0;
    int exp_wr_code = 0;
    bit exp_oor     = 0;
    int req_cnt     = 0;

    // Reference model state (written only by the monitor)
    int   mdl_ram [2048];
    int   m_last, m_rd_addr, m_st1, m_rgb, m_hold, m_clr_idx;
    bit   m_dirty, m_rd_vis, m_st1_v, m_busy, prev_tick;
    int   cyc = 0, n_rd = 0, n_wr = 0, n_ack = 0, n_tick = 0;
    int   wr_seen_cyc = 0, rd_cyc = 0, busy_fall_cyc = 0;

    // Per-cycle monitor: tile-level model of fetches, writes, colour and ticks
    initial begin
        int tile;
        forever begin
            @(negedge clk_fpga);
            if (!rst_n) begin
                m_last = -1; m_dirty = 1; m_rd_vis = 0; m_rd_addr = 0;
                m_st1_v = 0; m_st1 = 0; m_rgb = 0; m_hold = 0;
                m_busy = 0; m_clr_idx = 0; prev_tick = 0;
                for (int i = 0; i < 2048; i++) mdl_ram[i] = int'(preset(i));
            end else begin
                check("rgb_data", rgb_data, m_rgb);
                if (m_rd_vis) begin
                    check("read_addr", mem_addr, m_rd_addr);
                    check("read_we", mem_we, 0);
                    m_hold = m_rd_addr;
                    rd_cyc = cyc;
                end else if (!mem_we) begin
                    check("addr_hold", mem_addr, m_hold);
                end
                if (mem_we) begin
                    if (m_busy) begin
                        check("clr_addr", mem_addr, m_clr_idx);
                        check("clr_data", mem_wdata, 0);
                        mdl_ram[m_clr_idx] = 0;
                        m_hold = m_clr_idx;
                        if (m_clr_idx == m_last) m_dirty = 1;
                        m_clr_idx++;
                        if (m_clr_idx == 1900) begin
                            m_busy = 0;
                            busy_fall_cyc = cyc;
                        end
                    end else begin
                        check("wr_expected", int'(req_cnt > n_wr), 1);
                        check("wr_addr", mem_addr, exp_wr_addr);
                        check("wr_data", mem_wdata, exp_wr_code);
                        mdl_ram[exp_wr_addr] = exp_wr_code;
                        m_hold = exp_wr_addr;
                        if (exp_wr_addr == m_last) m_dirty = 1;
                        n_wr++;
                        wr_seen_cyc = cyc;
                    end
                end
                check("clr_busy", clr_busy, int'(m_busy));
                if (wr_ack) begin
                    check("wr_err_on_ack", wr_err, int'(exp_oor));
                    if (!exp_oor) check("ack_after_write", cyc - wr_seen_cyc, 1);
                    n_ack++;
                end else begin
                    check("wr_err_alone", wr_err, 0);
                end
                if (frame_tick) begin
                    check("tick_not_adjacent", int'(prev_tick), 0);
                    n_tick++;
                end
                prev_tick = frame_tick;
                if (clr_req && !m_busy) begin
                    m_busy = 1;
                    m_clr_idx = 0;
                end
                // advance: colour lags the fetch by two cycles
                if (m_st1_v) m_rgb = m_st1;
                m_st1_v = m_rd_vis;
                if (m_rd_vis) m_st1 = pal(mdl_ram[m_rd_addr]);
                tile = (int'(y) / 16) * 50 + int'(x) / 16;
                if (tile != m_last || m_dirty) begin
                    m_rd_vis = 1; m_rd_addr = tile; m_last = tile; m_dirty = 0;
                    n_rd++;
                end else begin
                    m_rd_vis = 0;
                end
                cyc++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_fpga);
        #2;
    endtask

    // Issue one write request and hold it until acknowledged (bounded wait)
    task automatic do_write(input int col, input int row, input int code, input bit oor,
                            input bit sweep, input bit with_clr, output int lat);
        int  start;
        bit  got;
        exp_wr_addr = row * 50 + col;
        exp_wr_code = code;
        exp_oor     = oor;
        if (!oor) req_cnt++;
        wr_col  = 6'(col);
        wr_row  = 6'(row);
        wr_code = 3'(code);
        wr_req  = 1'b1;
        if (with_clr) clr_req = 1'b1;
        start = cyc;
        got   = 0;
        for (int i = 0; i < 5000; i++) begin
            step(1);
            clr_req = 1'b0;
            if (sweep) x = 12'((int'(x) + 1) % 800);
            if (wr_ack) begin
                got = 1;
                break;
            end
        end
        wr_req = 1'b0;
        check("wr_ack_seen", int'(got), 1);
        lat = wr_seen_cyc - start;
    endtask

    initial begin
        int lat, rd0, wr0;
        rst_n = 1'b0; x = '0; y = '0; vga_v_out = 1'b1;
        wr_req = 1'b0; wr_col = '0; wr_row = '0; wr_code = '0; clr_req = 1'b0;
        step(3);
        check("rst_rgb", rgb_data, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_ack", wr_ack, 0);
        check("rst_err", wr_err, 0);
        check("rst_busy", clr_busy, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;

        // static pixel at the origin: a single fetch of tile 0 (body)
        step(8);
        check("static_reads", n_rd, 1);
        check("static_rgb", rgb_data, 6'b001100);
        check("static_no_we", n_wr, 0);

        // sweep across tiles 50..52 on pixel row 16
        rd0 = n_rd;
        y = 12'd16;
        for (int xi = 0; xi < 48; xi++) begin
            x = 12'(xi);
            step(1);
        end
        step(3);
        check("sweep_reads", n_rd - rd0, 3);
        check("sweep_rgb_wall", rgb_data, 6'b010101);

        // in-range write while the beam keeps moving
        wr0 = n_wr;
        do_write(3, 2, 3, 1'b0, 1'b1, 1'b0, lat);
        check("wr_count", n_wr - wr0, 1);
        check("wr_latency_ok", int'(lat >= 2 && lat <= 3), 1);

        // writes to the tile on screen force a refetch
        x = 12'd48; y = 12'd32;
        step(4);
        check("tile103_food", rgb_data, 6'b110000);
        do_write(3, 2, 2, 1'b0, 1'b0, 1'b0, lat);
        step(4);
        check("reread_delay", rd_cyc - wr_seen_cyc, 1);
        check("tile103_head", rgb_data, 6'b111100);
        do_write(3, 2, 3, 1'b0, 1'b0, 1'b0, lat);
        step(4);
        check("tile103_food_again", rgb_data, 6'b110000);

        // out-of-range column and row
        wr0 = n_wr;
        do_write(50, 0, 1, 1'b1, 1'b0, 1'b0, lat);
        do_write(0, 38, 1, 1'b1, 1'b0, 1'b0, lat);
        step(2);
        check("oor_no_write", n_wr - wr0, 0);

        // clear requested together with a held write: clear first, then the write
        x = '0; y = 12'd16;
        wr0 = n_wr;
        do_write(5, 1, 4, 1'b0, 1'b1, 1'b1, lat);
        check("clr_writes", m_clr_idx, 1900);
        check("busy_low_at_ack", clr_busy, 0);
        check("ack_after_clear", int'(wr_seen_cyc > busy_fall_cyc), 1);
        check("post_clr_write", n_wr - wr0, 1);
        x = 12'd80; y = 12'd16;
        step(4);
        check("tile55_wall", rgb_data, 6'b010101);
        x = '0; y = '0;
        step(4);
        check("tile0_cleared", rgb_data, 6'b000000);

        // two vsync falls give two frame ticks
        check("no_tick_yet", n_tick, 0);
        for (int f = 0; f < 2; f++) begin
            vga_v_out = 1'b0;
            step(10);
            vga_v_out = 1'b1;
            step(10);
        end
        check("frame_ticks", n_tick, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/vga_tile_arbiter.md
Name: vga_tile_arbiter

Overview:
- Owns the single-port tile-map RAM that holds the snake playfield. It shares that RAM between two users: the pixel fetch driven by vga_out x/y, and the game engine's tile writes and full-map clear.
- Converts each stored tile code into the 6-bit rgb_data that vga_out consumes.
- Emits a once-per-frame tick for the game logic.
- Sits between the game engine, the tile RAM and vga_out, in the clk_fpga (49.5 MHz) domain.

Parameters:
- TILE_SHIFT, 4, log2 of tile size in pixels (16x16 tiles).
- COLS, 50, tiles per row (800 >> TILE_SHIFT).
- ROWS, 38, tile rows; row 37 is partial (600/16 = 37.5).
- CODE_W, 3, tile code width.
- ADDR_W, 11, RAM address width (COLS*ROWS = 1900 entries).

Ports:
- clk_fpga  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- x  in  12  pixel column from vga_out; 0 outside the active area.
- y  in  12  pixel row from vga_out; 0 outside the active area.
- vga_v_out  in  1  vsync from vga_out; active low.
- rgb_data  out  6  2:2:2 colour to vga_out.
- frame_tick  out  1  one-cycle pulse per frame.
- wr_req  in  1  game write request; held high until wr_ack.
- wr_col  in  6  target column.
- wr_row  in  6  target row.
- wr_code  in  CODE_W  tile code to write.
- wr_ack  out  1  one-cycle pulse when the write is retired.
- wr_err  out  1  one-cycle pulse together with wr_ack when col/row is out of range.
- clr_req  in  1  pulse; starts a fill of the whole map with code 0.
- clr_busy  out  1  high while a clear is in progress.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  CODE_W  RAM write data.
- mem_rdata  in  CODE_W  RAM read data; 1-cycle latency.

Behaviour:
- Reset values: rgb_data=0, frame_tick=0, wr_ack=0, wr_err=0, clr_busy=0, mem_we=0, mem_addr=0, mem_wdata=0. Internal: last_addr=all-ones, dirty=1, FSM=IDLE.
- Tile address: pix_addr = (y>>TILE_SHIFT)*COLS + (x>>TILE_SHIFT). The multiply is by a constant, implemented as shift-add, never as a divide.
- Read slot: a cycle is a read slot when pix_addr != last_addr or dirty=1.
- Read slot action: drive mem_addr=pix_addr with mem_we=0, set last_addr=pix_addr, clear dirty.
- Reads have absolute priority over writes and clears.
- Colour pipeline latency:
  - cycle N: address issued;
  - cycle N+1: mem_rdata valid;
  - cycle N+2: rgb_data = palette(mem_rdata).
  - rgb_data holds between reads.
  - The fixed 2-pixel lag, plus vga_out's own register, is accepted; game graphics leave a 3-pixel margin.
- Write port use: a non-read-slot cycle is free for the write port.
- FSM states: IDLE, WR_PEND, CLEAR.
  - IDLE: clr_req=1 -> CLEAR, with clr_busy=1 and clear index=0. Otherwise wr_req=1 -> WR_PEND. clr_req wins when both are present.
  - WR_PEND, out-of-range request (wr_col>=COLS or wr_row>=ROWS): no RAM access; wr_ack=1 and wr_err=1 next cycle; -> IDLE.
  - WR_PEND, in-range request: on the first free cycle, drive mem_we=1, mem_addr=wr_row*COLS+wr_col, mem_wdata=wr_code. wr_ack pulses the following cycle; -> IDLE.
  - WR_PEND wait bound: at most 1 cycle in the active area (reads occur at most once every 16 cycles).
  - CLEAR: write code 0 to the current index on every free cycle and increment the index. After writing index COLS*ROWS-1, deassert clr_busy and -> IDLE. wr_req is not serviced during CLEAR (wr_ack withheld). clr_req during CLEAR is ignored.
- Coherence: any RAM write whose address equals last_addr sets dirty=1, so the new tile shows within 3 cycles.
- Palette:
  - 0 background -> 6'b000000
  - 1 body -> 6'b001100
  - 2 head -> 6'b111100
  - 3 food -> 6'b110000
  - 4 wall -> 6'b010101
  - 5-7 -> 6'b111111
- frame_tick: vga_v_out is generated off an hs-derived clock, so it passes through a 2-flop synchroniser. frame_tick pulses one cycle on the synchronised falling edge: exactly one pulse per frame, never two in adjacent cycles.
- Reset mid-operation: an in-flight write or clear is abandoned with no ack; the map contents are undefined until the next clear.
- wr_* inputs must stay stable while wr_req is high. A wr_req drop before ack is a protocol violation; the write may still retire.

Decomposition:
- Shared package snake_pkg:
  - tile code constants: TILE_BG, TILE_BODY, TILE_HEAD, TILE_FOOD, TILE_WALL;
  - palette function;
  - COLS, ROWS, TILE_SHIFT;
  - FSM state enum.
- One sub-module: tile_addr_calc, the combinational row*COLS+col shift-add. It is instantiated twice: once for the pixel address, once for the write address.

Test Plan:
- Reset then static x=0,y=0 with mem_rdata=1 -> exactly one read, at addr 0; rgb_data=6'b001100 two cycles after it; mem_we stays 0.
- Sweep x=0..47 on a row with y=16 -> reads only at addr 50, 51, 52, one read every 16 cycles; no read on other cycles.
- wr_req with col=3,row=2,code=3 while x sweeps -> mem_we at addr 103 on a non-read cycle within 2 cycles; wr_ack one cycle later; wr_err=0.
- Write to the currently displayed tile (last_addr=103) -> dirty set; re-read of 103 within 2 cycles; rgb_data becomes 6'b110000.
- wr_req with col=50,row=0 -> wr_ack=1 and wr_err=1 together; no mem_we.
- clr_req while wr_req is held -> 1900 writes of 0 interleaved with reads; clr_busy falls after addr 1899; the pending write is acked afterwards. Separately, drive vga_v_out falling twice -> exactly two frame_tick pulses.
